fm_operand_sched: RTL and testbench

FM_OPERAND_SCHED -- requirements
Module: fm_operand_sched

---
 rtl/fm_pkg.sv | 36 +++
 rtl/fm_sched_out_reg.sv | 46 ++++
 rtl/fm_operand_sched.sv | 161 ++++++++++++++++
 tb/tb_fm_operand_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// ============================================================================
// Module   : fm_pkg
// Summary  : Shared state type, default sizing constants and index-wrap helper
//            for the FM operand scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fm_pkg;

    localparam int C_GEN_NUM = 200;
    localparam int C_N       = 64;
    localparam int C_Q       = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } sched_state_t;

    // (base + off) mod depth for base < depth and off <= 2, without a divider.
    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned depth);
        int unsigned s;
        s = base + off;
        if (s >= depth) s = s - depth;
        if (s >= depth) s = s - depth;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fm_sched_out_reg.sv
// ============================================================================
// Module   : fm_sched_out_reg
// Summary  : Single-entry valid/ready output register with abort clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fm_sched_out_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic         i_ready,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_can_load
);

    logic [W-1:0] r_data;
    logic         r_valid;

    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_can_load = !r_valid || i_ready;

    // Payload only changes on load, so it stays stable through any stall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fm_operand_sched.sv
// ============================================================================
// Module   : fm_operand_sched
// Summary  : Triggers the operand generator, then streams GEN_NUM wrapped
//            index triplets downstream. Optional perf counters: FM_SCHED_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fm_operand_sched
    import fm_pkg::*;
#(
    parameter int GEN_NUM       = C_GEN_NUM,
    parameter int GEN_NUM_WIDTH = (GEN_NUM > 1) ? $clog2(GEN_NUM) : 1,
    parameter int N             = C_N,
    parameter int Q             = C_Q
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     gen_en,
    input  logic                     gen_done,
    output logic [GEN_NUM_WIDTH-1:0] idx0,
    output logic [GEN_NUM_WIDTH-1:0] idx1,
    output logic [GEN_NUM_WIDTH-1:0] idx2,
    input  logic [N-1:0]             op0,
    input  logic [N-1:0]             op1,
    input  logic [N-1:0]             op2,
    output logic [N-1:0]             out_a,
    output logic [N-1:0]             out_b,
    output logic [N-1:0]             out_c,
    output logic [GEN_NUM_WIDTH-1:0] out_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
`ifdef FM_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_cycles,
    output logic [31:0]              perf_stalls
`endif
);

    localparam int C_PAY_W = 3 * N + GEN_NUM_WIDTH;

    if (Q >= N) begin : g_q_range
        $error("fm_operand_sched: Q must be smaller than N");
    end

    sched_state_t             r_state;
    logic [GEN_NUM_WIDTH-1:0] r_k;
    logic                     r_gen_en;
    logic                     r_done;
    logic                     w_can_load;
    logic                     w_load;
    logic                     w_clear;
    logic                     w_last;
    logic [C_PAY_W-1:0]       w_payload;
    logic [C_PAY_W-1:0]       w_q;

    assign idx0 = r_k;
    assign idx1 = GEN_NUM_WIDTH'(wrap_idx(32'(r_k), 32'd1, 32'(GEN_NUM)));
    assign idx2 = GEN_NUM_WIDTH'(wrap_idx(32'(r_k), 32'd2, 32'(GEN_NUM)));

    assign w_last    = (r_k == GEN_NUM_WIDTH'(GEN_NUM - 1));
    assign w_clear   = abort && (r_state != S_IDLE);
    assign w_load    = (r_state == S_ISSUE) && w_can_load && !abort;
    assign w_payload = {op0, op1, op2, r_k};

    assign gen_en = r_gen_en;
    assign done   = r_done;
    assign busy   = (r_state != S_IDLE);
    assign {out_a, out_b, out_c, out_tag} = w_q;

    fm_sched_out_reg #(
        .W (C_PAY_W)
    ) u_out_reg (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_ready    (out_ready),
        .i_data     (w_payload),
        .o_data     (w_q),
        .o_valid    (out_valid),
        .o_can_load (w_can_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_gen_en <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_gen_en <= 1'b0;
            r_done   <= 1'b0;
            if (w_clear) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_gen_en <= 1'b1;
                            r_state  <= S_GEN;
                        end
                    end
                    S_GEN: begin
                        if (gen_done) begin
                            r_k     <= '0;
                            r_state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        // k advances with the same wrap as idx1 so it never leaves range.
                        if (w_load) begin
                            r_k <= idx1;
                            if (w_last) r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (out_valid && out_ready) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                    S_FIN:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef FM_SCHED_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;
    logic        w_perf_active;

    assign w_perf_active = (r_state == S_GEN) || (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign perf_cycles   = r_perf_cycles;
    assign perf_stalls   = r_perf_stalls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_perf_active && (r_perf_cycles != '1))
                r_perf_cycles <= r_perf_cycles + 32'd1;
            if (out_valid && !out_ready && (r_perf_stalls != '1))
                r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fm_operand_sched.sv
// ============================================================================
// Module   : tb_fm_operand_sched
// Summary  : Randomised self-checking bench against a triplet/tag stream model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fm_operand_sched;

    localparam int G  = 8;
    localparam int W  = 3;
    localparam int G3 = 3;
    localparam int W3 = 2;

    logic clk = 1'b0;
    logic rst, start, abort, gen_done, out_ready;
    logic start3, abort3, gen_done3, ready3;
    logic [31:0] salt = 32'h0;

    logic          gen_en, out_valid, busy, done;
    logic [W-1:0]  idx0, idx1, idx2, out_tag;
    logic [63:0]   op0, op1, op2, out_a, out_b, out_c;
    logic          gen_en3, valid3, busy3, done3;
    logic [W3-1:0] i30, i31, i32, tag3;
    logic [63:0]   o30, o31, o32, a3, b3, c3;
`ifdef FM_SCHED_PERF_EN
    logic [31:0] perf_cycles, perf_stalls, pc3, ps3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Generator buffer content: a per-run salt mixed with the index.
    function automatic logic [63:0] gd(input logic [31:0] s, input int unsigned i);
        return {s ^ (i * 32'd2654435761), 32'hC0DE_0000 | i};
    endfunction

    assign op0 = gd(salt, 32'(idx0));
    assign op1 = gd(salt, 32'(idx1));
    assign op2 = gd(salt, 32'(idx2));
    assign o30 = gd(salt, 32'(i30));
    assign o31 = gd(salt, 32'(i31));
    assign o32 = gd(salt, 32'(i32));

    fm_operand_sched #(.GEN_NUM(G), .GEN_NUM_WIDTH(W), .N(64), .Q(15)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gen_en(gen_en),
        .gen_done(gen_done), .idx0(idx0), .idx1(idx1), .idx2(idx2),
        .op0(op0), .op1(op1), .op2(op2), .out_a(out_a), .out_b(out_b), .out_c(out_c),
        .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
`ifdef FM_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    fm_operand_sched #(.GEN_NUM(G3), .GEN_NUM_WIDTH(W3), .N(64), .Q(15)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .gen_en(gen_en3),
        .gen_done(gen_done3), .idx0(i30), .idx1(i31), .idx2(i32),
        .op0(o30), .op1(o31), .op2(o32), .out_a(a3), .out_b(b3), .out_c(c3),
        .out_tag(tag3), .out_valid(valid3), .out_ready(ready3),
        .busy(busy3), .done(done3)
`ifdef FM_SCHED_PERF_EN
        , .perf_cycles(pc3), .perf_stalls(ps3)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; gen_done = 1'b0; out_ready = 1'b0;
        start3 = 1'b0; abort3 = 1'b0; gen_done3 = 1'b0; ready3 = 1'b0;
        repeat (3) tick;
        checks++;
        if ({out_valid, gen_en, done, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl: got %b, expected 0000", {out_valid, gen_en, done, busy});
        end
        checks++;
        if ((out_a | out_b | out_c) !== 64'h0 || out_tag !== 3'd0) begin
            errors++; $display("FAIL reset_data: got a=%h b=%h c=%h tag=%0d, expected all 0", out_a, out_b, out_c, out_tag);
        end
        checks++;
        if (idx0 !== 3'd0 || idx1 !== 3'd1 || idx2 !== 3'd2) begin
            errors++; $display("FAIL reset_idx: got %0d/%0d/%0d, expected 0/1/2", idx0, idx1, idx2);
        end
        rst = 1'b0;
        tick;
        gen_done = 1'b1; abort = 1'b1;
        tick;
        gen_done = 1'b0; abort = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || gen_en !== 1'b0) begin
            errors++; $display("FAIL idle_ignore: got busy=%b gen_en=%b, expected 0/0", busy, gen_en);
        end
    endtask

    // Start a run (abort coinciding with start must lose) and feed gen_done after gen_delay cycles.
    task automatic start_run(input int gen_delay);
        salt  = $urandom;
        start = 1'b1;
        abort = 1'($urandom_range(0, 1));
        tick;
        start = 1'b0; abort = 1'b0;
        checks++;
        if (gen_en !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL start_gen_en: got gen_en=%b busy=%b, expected 1/1", gen_en, busy);
        end
        for (int i = 1; i < gen_delay; i++) begin
            start = 1'($urandom_range(0, 1));
            tick;
            checks++;
            if (gen_en !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL gen_wait: got gen_en=%b busy=%b valid=%b, expected 0/1/0", gen_en, busy, out_valid);
            end
        end
        start = 1'b0;
        gen_done = 1'b1;
        tick;
        gen_done = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL issue_entry: got valid=%b busy=%b, expected 0/1", out_valid, busy);
        end
    endtask

    // Modes: 0 ready high, 1 ready toggles, 2 random ready + random start, 3 five-cycle stall at tag 2.
    task automatic run_stream(input int mode, output int n_acc, output int n_stall,
                              output int first_v, output int last_acc);
        int   exp_tag = 0;
        int   stall_left = 5;
        bit   prev_stall = 1'b0;
        bit   fin = 1'b0;
        bit   r;
        logic [3*64+W-1:0] held = '0;
        n_acc = 0; n_stall = 0; first_v = -1; last_acc = -1;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                2:       r = 1'($urandom_range(0, 1));
                default: r = !(out_valid === 1'b1 && out_tag === 3'd2 && stall_left > 0);
            endcase
            if (mode == 3 && !r) stall_left--;
            if (mode == 2) start = 1'($urandom_range(0, 1));
            out_ready = r;
            checks++;
            if (gen_en !== 1'b0) begin
                errors++; $display("FAIL stream_gen_en: got %b, expected 0", gen_en);
            end
            if (out_valid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                if (prev_stall) begin
                    checks++;
                    if ({out_a, out_b, out_c, out_tag} !== held) begin
                        errors++; $display("FAIL stall_hold: tag %0d payload changed, expected tag %0d held", out_tag, held[W-1:0]);
                    end
                end
                if (r) begin
                    checks++;
                    if (32'(out_tag) !== exp_tag || out_a !== gd(salt, exp_tag) ||
                        out_b !== gd(salt, (exp_tag + 1) % G) || out_c !== gd(salt, (exp_tag + 2) % G)) begin
                        errors++;
                        $display("FAIL accept: got tag=%0d a=%h b=%h c=%h, expected tag=%0d a=%h b=%h c=%h",
                                 out_tag, out_a, out_b, out_c, exp_tag, gd(salt, exp_tag),
                                 gd(salt, (exp_tag + 1) % G), gd(salt, (exp_tag + 2) % G));
                    end
                    exp_tag++; n_acc++; last_acc = cyc;
                end else begin
                    held = {out_a, out_b, out_c, out_tag};
                    n_stall++;
                end
            end
            prev_stall = (out_valid === 1'b1) && !r;
            if (done === 1'b1) begin
                checks++;
                if (exp_tag != G) begin
                    errors++; $display("FAIL done_early: got done after %0d tags, expected %0d", exp_tag, G);
                end
                fin = 1'b1;
            end
            tick;
        end
        start = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL stream_timeout: got %0d tags and no done, expected %0d tags then done", exp_tag, G);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL post_run: got done=%b busy=%b valid=%b, expected 0/0/0", done, busy, out_valid);
            end
            tick;
        end
    endtask

    task automatic test_basic;
        int n_acc, n_stall, fv, la;
        start_run(3);
        run_stream(0, n_acc, n_stall, fv, la);
        checks++;
        if (n_acc != G || la - fv != G - 1) begin
            errors++; $display("FAIL basic_burst: got %0d tags over %0d cycles, expected %0d over %0d", n_acc, la - fv + 1, G, G);
        end
    endtask

    task automatic test_backpressure;
        int n_acc, n_stall, fv, la;
        start_run(2);
        run_stream(1, n_acc, n_stall, fv, la);
        checks++;
        if (n_acc != G || n_stall == 0) begin
            errors++; $display("FAIL toggle_ready: got %0d tags %0d stalls, expected %0d tags with stalls", n_acc, n_stall, G);
        end
    endtask

    task automatic test_random_start_during_issue;
        int n_acc, n_stall, fv, la;
        for (int it = 0; it < 4; it++) begin
            start_run(int'($urandom_range(1, 5)));
            run_stream(2, n_acc, n_stall, fv, la);
            checks++;
            if (n_acc != G) begin
                errors++; $display("FAIL random_run: got %0d tags, expected %0d", n_acc, G);
            end
        end
    endtask

    task automatic test_abort;
        bit hit = 1'b0;
        start_run(3);
        out_ready = 1'b1;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (out_valid === 1'b1 && out_tag === 3'd4) begin
                hit = 1'b1;
                abort = 1'b1;
            end
            tick;
        end
        abort = 1'b0;
        checks++;
        if (!hit || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort: got hit=%b valid=%b busy=%b done=%b, expected 1/0/0/0", hit, out_valid, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL abort_quiet: got done=%b busy=%b, expected 0/0", done, busy);
            end
        end
    endtask

    task automatic test_reset_in_drain;
        bit hit = 1'b0;
        start_run(1);
        out_ready = 1'b1;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (out_valid === 1'b1 && out_tag === 3'd7) begin
                hit = 1'b1;
                out_ready = 1'b0;
            end
            tick;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!hit || {out_valid, busy, gen_en, done} !== 4'b0000 || (out_a | out_b | out_c) !== 64'h0 ||
            out_tag !== 3'd0 || idx0 !== 3'd0) begin
            errors++; $display("FAIL async_reset: got hit=%b valid=%b busy=%b tag=%0d idx0=%0d a=%h, expected 1/0/0/0/0/0",
                               hit, out_valid, busy, out_tag, idx0, out_a);
        end
        #2 rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_restart: got busy=%b valid=%b done=%b, expected 0/0/0", busy, out_valid, done);
        end
    endtask

    // Non-power-of-two depth: indices must wrap at 3, not 4.
    task automatic test_small_depth;
        int exp_tag = 0;
        int n_done = 0;
        salt = $urandom;
        start3 = 1'b1; tick; start3 = 1'b0;
        gen_done3 = 1'b1; tick; gen_done3 = 1'b0;
        ready3 = 1'b1;
        for (int i = 0; i < 20 && n_done == 0; i++) begin
            if (valid3 === 1'b1) begin
                checks++;
                if (32'(tag3) !== exp_tag || a3 !== gd(salt, exp_tag) ||
                    b3 !== gd(salt, (exp_tag + 1) % G3) || c3 !== gd(salt, (exp_tag + 2) % G3)) begin
                    errors++; $display("FAIL small_triplet: got tag=%0d b=%h c=%h, expected tag=%0d b=%h c=%h", tag3, b3, c3,
                                       exp_tag, gd(salt, (exp_tag + 1) % G3), gd(salt, (exp_tag + 2) % G3));
                end
                exp_tag++;
            end
            if (done3 === 1'b1) n_done++;
            tick;
        end
        ready3 = 1'b0;
        checks++;
        if (exp_tag != G3 || n_done != 1 || busy3 !== 1'b0) begin
            errors++; $display("FAIL small_run: got %0d tags %0d done busy=%b, expected %0d/1/0", exp_tag, n_done, busy3, G3);
        end
    endtask

`ifdef FM_SCHED_PERF_EN
    task automatic test_perf;
        int n_acc, n_stall, fv, la;
        start_run(2);
        run_stream(3, n_acc, n_stall, fv, la);
        checks++;
        if (perf_stalls !== 32'd5 || perf_cycles !== 32'(2 + G + 5 + 1)) begin
            errors++; $display("FAIL perf: got cycles=%0d stalls=%0d, expected %0d/5", perf_cycles, perf_stalls, 2 + G + 5 + 1);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_random_start_during_issue;
        test_abort;
        test_reset_in_drain;
        test_small_depth;
`ifdef FM_SCHED_PERF_EN
        test_perf;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
